bus_arb_reg: RTL and testbench
==============================

Name: bus_arb_reg

Overview:
- Parametrised, registered successor to the datapath bus encoder/mux.
- Selects one of NSRC WIDTH-bit sources onto the shared bus, with one cycle of latency.
- Resolves multiple simultaneous drive requests by fixed-priority or round-robin arbitration, supports grant locking for multi-cycle transfers, and flags drive conflicts.
- Sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers in the datapath.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NSRC, 24, number of bus sources (R0-R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C).
- IDXW, $clog2(NSRC), width of the grant index.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- IDLE_HOLD, 1, 1 = bus_out holds its last value when idle, 0 = bus_out goes to zero when idle.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-high reset.
- src_en  in  NSRC  per-source drive request; bit i = source i.
- src_data  in  NSRC*WIDTH  flattened source data; source i occupies [i*WIDTH +: WIDTH].
- lock  in  1  hold the current grant while its source keeps requesting.
- conflict_clr  in  1  clears conflict_sticky.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out carries a granted source this cycle.
- grant_idx  out  IDXW  index of the source currently reflected on bus_out.
- conflict  out  1  one-cycle pulse aligned with bus_out; more than one src_en bit was set.
- conflict_sticky  out  1  latched conflict flag.

Behaviour:
- Reset: when clr=1 at an edge, bus_out=0, bus_valid=0, grant_idx=0, conflict=0, conflict_sticky=0, and the round-robin pointer is set to NSRC-1 so the first search starts at index 0. clr overrides every other input.
- Latency: src_en and src_data sampled at edge t appear on bus_out, grant_idx, bus_valid and conflict after edge t. Exactly 1 cycle, no bypass path.
- Arbitration, ARB_MODE=0: the lowest set index of src_en wins.
- Arbitration, ARB_MODE=1: search starts at (ptr+1) mod NSRC, wraps past NSRC-1 to 0, and the first set bit wins.
  - ptr is updated to the winner only on a granted cycle.
  - ptr is unchanged on idle cycles and locked cycles.
- Lock:
  - Condition: lock=1, bus_valid=1 and src_en[grant_idx]=1.
  - Effect: the grant is kept and bus_out re-registers the current src_data[grant_idx], so data tracks the source.
  - If the locked source drops its request, lock is ignored and normal arbitration applies in the same cycle.
  - lock with bus_valid=0 has no effect.
- Idle (src_en=0):
  - bus_valid=0; grant_idx holds.
  - bus_out holds if IDLE_HOLD=1, else is 0.
- Conflict:
  - conflict=1 whenever popcount(src_en)>1, whether or not lock is active.
  - conflict_sticky sets on any conflict and clears on conflict_clr.
  - Simultaneous set and clear: set wins.
- No X propagation: src_data of non-granted sources never affects outputs.
- NSRC=1 is legal: no arbitration, conflict is constant 0.

Optional Feature:
- Macro BUS_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt [15:0], which counts conflict cycles.
  - The counter saturates at 16'hFFFF.
  - It is cleared by clr or conflict_clr; if conflict_clr and a conflict coincide, the counter loads 1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package bus_pkg holds:
  - default WIDTH/NSRC;
  - source index constants SRC_R0=0..SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23;
  - ARB_FIXED=0 and ARB_RR=1 constants.
- One sub-module, bus_grant_arb: combinational grant search (fixed or round-robin from ptr) plus the ptr register.
- Data muxing, registers, lock and conflict logic stay in the top level.

Test Plan:
- Reset: drive clr=1 with src_en=all-ones -> next cycle bus_out=0, bus_valid=0, conflict=0, conflict_sticky=0.
- Single source: src_en=1<<SRC_PC with PC=32'h0000_0040 -> one cycle later bus_out=32'h40, grant_idx=20, bus_valid=1, conflict=0.
- Fixed-priority conflict: ARB_MODE=0, src_en enables R3 (=32'hA) and MDR (=32'hB) -> bus_out=32'hA, grant_idx=3, conflict=1, sticky=1.
  - Then pulse conflict_clr with a conflict still present -> sticky stays 1.
- Round-robin wrap: ARB_MODE=1, src_en enables indices 0 and 23 for 3 cycles -> grants 0, 23, 0. Next, set src_en=0 for one cycle, then re-enable both -> grant 23 (ptr unchanged while idle).
- Lock: grant R5, hold lock=1 and add a request from R1 -> grant stays 5 while R5 data changes 1->2 (bus_out follows 1, 2). Then drop R5 -> grant_idx=1 the next cycle.
- Idle: IDLE_HOLD=1, after bus_out=32'hDEAD set src_en=0 -> bus_out=32'hDEAD, bus_valid=0.
  - With IDLE_HOLD=0 -> bus_out=0.
  - With BUS_CONFLICT_CNT_EN, after 3 conflict cycles -> conflict_cnt=3.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus defaults, source indices and arbitration modes
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 24;

  // Bus source indices
  localparam int SRC_R0  = 0;
  localparam int SRC_R1  = 1;
  localparam int SRC_R2  = 2;
  localparam int SRC_R3  = 3;
  localparam int SRC_R4  = 4;
  localparam int SRC_R5  = 5;
  localparam int SRC_R6  = 6;
  localparam int SRC_R7  = 7;
  localparam int SRC_R8  = 8;
  localparam int SRC_R9  = 9;
  localparam int SRC_R10 = 10;
  localparam int SRC_R11 = 11;
  localparam int SRC_R12 = 12;
  localparam int SRC_R13 = 13;
  localparam int SRC_R14 = 14;
  localparam int SRC_R15 = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Grant index width; a single-source bus still carries a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_reg_if.sv
// rtl/bus_arb_reg_if.sv - bus source/consumer signal bundle (conflict_cnt only with BUS_CONFLICT_CNT_EN)
interface bus_arb_reg_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int NSRC  = BUS_NSRC,
  parameter int IDXW  = idx_width(NSRC)
);

  logic [NSRC-1:0]       src_en;
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  lock;
  logic                  conflict_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [IDXW-1:0]       grant_idx;
  logic                  conflict;
  logic                  conflict_sticky;
`ifdef BUS_CONFLICT_CNT_EN
  logic [15:0]           conflict_cnt;
`endif

  modport master (
    output src_en, src_data, lock, conflict_clr,
    input  bus_out, bus_valid, grant_idx, conflict, conflict_sticky
`ifdef BUS_CONFLICT_CNT_EN
    , input conflict_cnt
`endif
  );

  modport slave (
    input  src_en, src_data, lock, conflict_clr,
    output bus_out, bus_valid, grant_idx, conflict, conflict_sticky
`ifdef BUS_CONFLICT_CNT_EN
    , output conflict_cnt
`endif
  );

endinterface

// File: rtl/bus_grant_arb.sv
// rtl/bus_grant_arb.sv - fixed-priority / round-robin grant search with its pointer register
module bus_grant_arb
  import bus_pkg::*;
#(
  parameter int NSRC     = BUS_NSRC,
  parameter int IDXW     = idx_width(NSRC),
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] req,
  input  logic            upd,
  output logic            gnt_any,
  output logic [IDXW-1:0] gnt_idx
);

  logic [IDXW-1:0] ptr;

  // First requester, scanning upward from 0 (fixed) or from ptr+1 with wrap (round-robin)
  always_comb begin
    int j;
    logic [IDXW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (ARB_MODE == ARB_RR) begin
        j = int'(ptr) + 1 + k;
        if (j >= NSRC) j = j - NSRC;
        if (j >= NSRC) j = j - NSRC;
      end else begin
        j = k;
      end
      jj = IDXW'(j);
      if (!gnt_any && req[jj]) begin
        gnt_any = 1'b1;
        gnt_idx = jj;
      end
    end
  end

  // Pointer follows the winner of each freshly arbitrated cycle; reset makes the first search start at 0
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= IDXW'(NSRC - 1);
    end else if (upd && gnt_any) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/bus_arb_reg.sv
// rtl/bus_arb_reg.sv - registered arbitrated bus mux with lock and conflict flags (optional BUS_CONFLICT_CNT_EN)
module bus_arb_reg
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int NSRC      = BUS_NSRC,
  parameter int IDXW      = idx_width(NSRC),
  parameter int ARB_MODE  = ARB_FIXED,
  parameter int IDLE_HOLD = 1
) (
  input logic         clk,
  input logic         clr,
  bus_arb_reg_if.slave bus
);

  logic [WIDTH-1:0] bus_q;
  logic             valid_q;
  logic [IDXW-1:0]  grant_q;
  logic             conflict_q;
  logic             sticky_q;

  logic             arb_any;
  logic [IDXW-1:0]  arb_idx;
  logic             lock_hold;
  logic             sel_any;
  logic [IDXW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             multi;

  // Lock only holds a live grant whose source is still requesting
  assign lock_hold = bus.lock && valid_q && bus.src_en[grant_q];
  assign sel_any   = lock_hold || arb_any;
  assign sel_idx   = lock_hold ? grant_q : arb_idx;
  assign multi     = |(bus.src_en & (bus.src_en - NSRC'(1)));

  bus_grant_arb #(
    .NSRC     (NSRC),
    .IDXW     (IDXW),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .clr     (clr),
    .req     (bus.src_en),
    .upd     (!lock_hold),
    .gnt_any (arb_any),
    .gnt_idx (arb_idx)
  );

  // Constant-index mux so only the selected source's data can reach the bus
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_idx == IDXW'(i)) sel_data = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  // Bus, grant and conflict registers
  always_ff @(posedge clk) begin
    if (clr) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      valid_q    <= sel_any;
      conflict_q <= multi;
      if (sel_any) begin
        grant_q <= sel_idx;
        bus_q   <= sel_data;
      end else if (IDLE_HOLD == 0) begin
        bus_q <= '0;
      end
      if (multi) begin
        sticky_q <= 1'b1;
      end else if (bus.conflict_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count of conflict cycles; a clear coinciding with a conflict counts that conflict
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (bus.conflict_clr) begin
      cnt_q <= multi ? 16'd1 : 16'd0;
    end else if (multi && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.conflict_cnt = cnt_q;
`endif

  assign bus.bus_out         = bus_q;
  assign bus.bus_valid       = valid_q;
  assign bus.grant_idx       = grant_q;
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;

endmodule

// File: tb/tb_bus_arb_reg.sv
// tb/tb_bus_arb_reg.sv - directed vector bench for bus_arb_reg (fixed/hold and round-robin/zero-idle instances)
module tb_bus_arb_reg;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic clr_a;
  logic clr_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bus_arb_reg_if #(.WIDTH(32), .NSRC(24)) ifa ();
  bus_arb_reg_if #(.WIDTH(32), .NSRC(24)) ifb ();

  bus_arb_reg #(.WIDTH(32), .NSRC(24), .ARB_MODE(ARB_FIXED), .IDLE_HOLD(1)) dut_a (
    .clk (clk),
    .clr (clr_a),
    .bus (ifa)
  );

  bus_arb_reg #(.WIDTH(32), .NSRC(24), .ARB_MODE(ARB_RR), .IDLE_HOLD(0)) dut_b (
    .clk (clk),
    .clr (clr_b),
    .bus (ifb)
  );

  typedef struct {
    logic        clr;
    logic [23:0] en;
    logic        lock;
    logic        cclr;
    int          ia;
    logic [31:0] va;
    int          ib;
    logic [31:0] vb;
    logic [31:0] e_bus;
    logic        e_valid;
    int          e_idx;
    logic        e_conf;
    logic        e_sticky;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic c, input logic [23:0] en, input logic lk, input logic cc,
                     input int ia, input logic [31:0] va, input int ib, input logic [31:0] vb,
                     input logic [31:0] eb, input logic ev, input int ei, input logic ec, input logic es);
    vec_t v;
    v.clr = c; v.en = en; v.lock = lk; v.cclr = cc;
    v.ia = ia; v.va = va; v.ib = ib; v.vb = vb;
    v.e_bus = eb; v.e_valid = ev; v.e_idx = ei; v.e_conf = ec; v.e_sticky = es;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Every source defaults to 0xC000_00ii; up to two sources overridden
  task automatic fill_a(input int ia, input logic [31:0] va, input int ib, input logic [31:0] vb);
    for (int i = 0; i < 24; i++) ifa.src_data[i*32 +: 32] = 32'hC000_0000 | i;
    if (ia >= 0) ifa.src_data[ia*32 +: 32] = va;
    if (ib >= 0) ifa.src_data[ib*32 +: 32] = vb;
  endtask

  task automatic step_b(input string nm, input logic [23:0] en, input logic [31:0] eb,
                        input logic ev, input int ei);
    ifb.src_en = en;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".bus"}, ifb.bus_out, eb);
    chk({nm, ".valid"}, {31'd0, ifb.bus_valid}, {31'd0, ev});
    chk({nm, ".idx"}, {27'd0, ifb.grant_idx}, ei);
  endtask

  initial begin
    logic [23:0] b0_23;
    clr_a = 1'b1; clr_b = 1'b1;
    ifa.src_en = '0; ifa.lock = 1'b0; ifa.conflict_clr = 1'b0;
    ifb.src_en = '0; ifb.lock = 1'b0; ifb.conflict_clr = 1'b0;
    fill_a(-1, 0, -1, 0);
    for (int i = 0; i < 24; i++) ifb.src_data[i*32 +: 32] = 32'hC000_0000 | i;

    //  clr  en                     lk  cc   ia   va         ib  vb     bus           v   idx conf sticky
    add(1, 24'hFFFFFF,              0, 0,  -1, 0,          -1, 0,     32'h0,        0,  0,  0,   0);
    add(0, 24'h1 << SRC_PC,         0, 0,  SRC_PC, 32'h40, -1, 0,     32'h40,       1,  20, 0,   0);
    add(0, 24'h000008 | (24'h1 << SRC_MDR), 0, 0, 3, 32'hA, SRC_MDR, 32'hB, 32'hA, 1, 3, 1,   1);
    add(0, 24'h000008 | (24'h1 << SRC_MDR), 0, 1, 3, 32'hA, SRC_MDR, 32'hB, 32'hA, 1, 3, 1,   1);
    add(0, 24'h1 << SRC_MDR,        0, 1,  SRC_MDR, 32'hB, -1, 0,     32'hB,        1,  21, 0,   0);
    add(0, 24'h000020,              0, 0,  5, 32'h1,       -1, 0,     32'h1,        1,  5,  0,   0);
    add(0, 24'h000022,              1, 0,  5, 32'h2,       -1, 0,     32'h2,        1,  5,  1,   1);
    add(0, 24'h000002,              1, 0,  1, 32'h77,      -1, 0,     32'h77,       1,  1,  0,   1);
    add(0, 24'h000080,              0, 0,  7, 32'hDEAD,    -1, 0,     32'hDEAD,     1,  7,  0,   1);
    add(0, 24'h000000,              0, 0,  -1, 0,          -1, 0,     32'hDEAD,     0,  7,  0,   1);
    add(0, 24'h000204,              1, 0,  -1, 0,          -1, 0,     32'hC0000002, 1,  2,  1,   1);
    add(0, 24'h000006,              1, 0,  -1, 0,          -1, 0,     32'hC0000002, 1,  2,  1,   1);
    add(0, 24'h000000,              0, 1,  -1, 0,          -1, 0,     32'hC0000002, 0,  2,  0,   0);
    add(0, 24'h000010,              0, 0,  -1, 0,          -1, 0,     32'hC0000004, 1,  4,  0,   0);
    add(1, 24'h000010,              0, 0,  -1, 0,          -1, 0,     32'h0,        0,  0,  0,   0);

    foreach (tv[n]) begin
      clr_a = tv[n].clr;
      ifa.src_en = tv[n].en;
      ifa.lock = tv[n].lock;
      ifa.conflict_clr = tv[n].cclr;
      fill_a(tv[n].ia, tv[n].va, tv[n].ib, tv[n].vb);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d.bus", n), ifa.bus_out, tv[n].e_bus);
      chk($sformatf("v%0d.valid", n), {31'd0, ifa.bus_valid}, {31'd0, tv[n].e_valid});
      chk($sformatf("v%0d.idx", n), {27'd0, ifa.grant_idx}, tv[n].e_idx);
      chk($sformatf("v%0d.conflict", n), {31'd0, ifa.conflict}, {31'd0, tv[n].e_conf});
      chk($sformatf("v%0d.sticky", n), {31'd0, ifa.conflict_sticky}, {31'd0, tv[n].e_sticky});
    end
    clr_a = 1'b0;
    ifa.lock = 1'b0;
    ifa.conflict_clr = 1'b0;

`ifdef BUS_CONFLICT_CNT_EN
    ifa.src_en = 24'h000006;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cnt.three", {16'd0, ifa.conflict_cnt}, 32'd3);
    ifa.conflict_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("cnt.clr_with_conflict", {16'd0, ifa.conflict_cnt}, 32'd1);
    ifa.conflict_clr = 1'b0;
    ifa.src_en = '0;
`endif

    // Round-robin wrap between sources 0 and 23, pointer frozen across an idle cycle
    b0_23 = 24'h800001;
    step_b("rr.reset", 24'hFFFFFF, 32'h0, 1'b0, 0);
    clr_b = 1'b0;
    step_b("rr.g0", b0_23, 32'hC0000000, 1'b1, 0);
    step_b("rr.g1", b0_23, 32'hC0000017, 1'b1, 23);
    step_b("rr.g2", b0_23, 32'hC0000000, 1'b1, 0);
    step_b("rr.idle", 24'h0, 32'h0, 1'b0, 0);
    step_b("rr.resume", b0_23, 32'hC0000017, 1'b1, 23);
    step_b("rr.single", 24'h000100, 32'hC0000008, 1'b1, 8);
    step_b("rr.after8", 24'h000101, 32'hC0000000, 1'b1, 0);
    chk("rr.conflict", {31'd0, ifb.conflict}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
